// File: rtl/led_ctrl_pkg.sv
// Shared opcodes, mode/FSM encodings and the preset mask table for the LED command controller.
package led_ctrl_pkg;

    localparam logic [7:0] OP_PRESET_BASE = 8'h80;
    localparam logic [7:0] OP_SET_MASK    = 8'h90;
    localparam logic [7:0] OP_MODE_BASE   = 8'hA0;
    localparam logic [7:0] OP_SET_RATE    = 8'hB0;
    localparam logic [7:0] NUM_PRESETS    = 8'd6;
    localparam logic [7:0] NUM_MODES      = 8'd3;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2
    } led_mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ARG = 1'b1
    } cmd_state_e;

    function automatic logic [7:0] preset_mask(input logic [2:0] idx);
        logic [7:0] m;
        case (idx)
            3'd0:    m = 8'b0000_0000;
            3'd1:    m = 8'b0000_0001;
            3'd2:    m = 8'b0000_0010;
            3'd3:    m = 8'b0000_0100;
            3'd4:    m = 8'b0000_1000;
            3'd5:    m = 8'b0000_1111;
            default: m = 8'b0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler plus rate counter: o_event pulses once every (i_rate+1)*TICK_DIV cycles after a restart.
// i_restart has priority and suppresses any event in the same cycle.
module led_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_rate,
    input  logic       i_restart,
    output logic       o_event
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_rcnt;
    logic          w_tick;
    logic          w_wrap;

    assign w_tick  = (r_presc == PW'(TICK_DIV - 1));
    // >= keeps the counter bounded even if the rate register ever shrinks below it
    assign w_wrap  = w_tick && (r_rcnt >= i_rate);
    assign o_event = w_wrap && !i_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_rcnt  <= '0;
        end else if (i_restart) begin
            r_presc <= '0;
            r_rcnt  <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_rcnt  <= w_wrap ? 8'd0 : r_rcnt + 8'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule

// File: rtl/led_cmd_ctrl.sv
// UART byte command decoder driving LED_W LEDs in static/blink/chase modes; led_out lags register writes by one cycle.
// Optional command acknowledge port enabled by defining LED_CMD_CTRL_ACK_EN.
module led_cmd_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int         LED_W       = 4,
    parameter int         TICK_DIV    = 100000,
    parameter int         ARG_TIMEOUT = 1000000,
    parameter logic [7:0] RATE_RST    = 8'd9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [LED_W-1:0] led_out,
    output logic             busy,
    output logic             cmd_err
`ifdef LED_CMD_CTRL_ACK_EN
    ,
    output logic [7:0]       ack_data,
    output logic             ack_valid
`endif
);

    localparam int TO_W = $clog2(ARG_TIMEOUT);

    cmd_state_e       r_state, w_state_nxt;
    logic [LED_W-1:0] r_mask, w_mask_nxt;
    led_mode_e        r_mode, w_mode_nxt;
    logic [7:0]       r_rate, w_rate_nxt;
    logic [7:0]       r_opc, w_opc_nxt;
    logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
    logic             r_phase;
    logic [LED_W-1:0] r_chase;
    logic [LED_W-1:0] r_led;
    logic             r_err;
    logic             w_err;
    logic             w_write;
    logic             w_event;
    logic [7:0]       w_preset;
    logic [LED_W-1:0] w_chase_rot;
    logic [LED_W-1:0] w_disp;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rate    (r_rate),
        .i_restart (w_write),
        .o_event   (w_event)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_mode_nxt  = r_mode;
        w_rate_nxt  = r_rate;
        w_opc_nxt   = r_opc;
        w_to_nxt    = r_to_cnt;
        w_err       = 1'b0;
        w_write     = 1'b0;
        w_preset    = preset_mask(rx_data[2:0]);
        case (r_state)
            ST_IDLE: begin
                w_to_nxt = '0;
                if (rx_valid) begin
                    if (rx_data >= OP_PRESET_BASE && rx_data < OP_PRESET_BASE + NUM_PRESETS) begin
                        w_mask_nxt = w_preset[LED_W-1:0];
                        w_write    = 1'b1;
                    end else if (rx_data >= OP_MODE_BASE && rx_data < OP_MODE_BASE + NUM_MODES) begin
                        w_mode_nxt = led_mode_e'(rx_data[1:0]);
                        w_write    = 1'b1;
                    end else if (rx_data == OP_SET_MASK || rx_data == OP_SET_RATE) begin
                        w_opc_nxt   = rx_data;
                        w_state_nxt = ST_WAIT_ARG;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_WAIT_ARG: begin
                // any byte value is a legal argument, including ones that look like opcodes
                if (rx_valid) begin
                    if (r_opc == OP_SET_MASK) begin
                        w_mask_nxt = rx_data[LED_W-1:0];
                    end else begin
                        w_rate_nxt = rx_data;
                    end
                    w_write     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_to_cnt == TO_W'(ARG_TIMEOUT - 1)) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    generate
        if (LED_W > 1) begin : g_rot
            assign w_chase_rot = {r_chase[LED_W-2:0], r_chase[LED_W-1]};
        end else begin : g_norot
            assign w_chase_rot = r_chase;
        end
    endgenerate

    always_comb begin
        w_disp = r_mask;
        case (r_mode)
            MODE_STATIC: w_disp = r_mask;
            MODE_BLINK:  w_disp = r_phase ? r_mask : '0;
            MODE_CHASE:  w_disp = r_chase;
            default:     w_disp = r_mask;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_mode   <= MODE_STATIC;
            r_rate   <= RATE_RST;
            r_opc    <= '0;
            r_to_cnt <= '0;
            r_phase  <= 1'b1;
            r_chase  <= '0;
            r_led    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mask   <= w_mask_nxt;
            r_mode   <= w_mode_nxt;
            r_rate   <= w_rate_nxt;
            r_opc    <= w_opc_nxt;
            r_to_cnt <= w_to_nxt;
            r_led    <= w_disp;
            r_err    <= w_err;
            // a command write restarts the display sequence from the new mask
            if (w_write) begin
                r_phase <= 1'b1;
                r_chase <= w_mask_nxt;
            end else if (w_event) begin
                r_phase <= ~r_phase;
                r_chase <= w_chase_rot;
            end
        end
    end

    assign led_out = r_led;
    assign busy    = (r_state == ST_WAIT_ARG);
    assign cmd_err = r_err;

`ifdef LED_CMD_CTRL_ACK_EN
    logic [7:0] r_ack_dat;
    logic       r_ack_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_dat <= '0;
            r_ack_vld <= 1'b0;
        end else begin
            r_ack_vld <= w_write;
            r_ack_dat <= w_write ? ((r_state == ST_WAIT_ARG) ? r_opc : rx_data) : 8'h00;
        end
    end

    assign ack_data  = r_ack_dat;
    assign ack_valid = r_ack_vld;
`endif

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Directed plus random byte stream against a cycle-level reference of the command/display rules.
module tb_led_cmd_ctrl;

    localparam int         LW   = 4;
    localparam int         TD   = 4;
    localparam int         ATO  = 20;
    localparam logic [7:0] RRST = 8'd2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [LW-1:0] led_out;
    logic          busy;
    logic          cmd_err;
`ifdef LED_CMD_CTRL_ACK_EN
    logic [7:0]    ack_data;
    logic          ack_valid;
`endif

    led_cmd_ctrl #(
        .LED_W(LW), .TICK_DIV(TD), .ARG_TIMEOUT(ATO), .RATE_RST(RRST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .led_out  (led_out),
        .busy     (busy),
        .cmd_err  (cmd_err)
`ifdef LED_CMD_CTRL_ACK_EN
        ,
        .ack_data (ack_data),
        .ack_valid(ack_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [LW-1:0] presets [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111};
    logic [LW-1:0] m_mask, m_chase;
    int            m_mode, m_rate, m_elapsed, m_wait_cnt;
    logic          m_phase, m_wait;
    logic [7:0]    m_opc;
    logic [LW-1:0] exp_led;
    logic          exp_busy, exp_err, exp_ack_vld;
    logic [7:0]    exp_ack_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = '0; m_chase = '0; m_mode = 0; m_rate = int'(RRST);
        m_phase = 1'b1; m_wait = 1'b0; m_opc = 8'h00; m_wait_cnt = 0; m_elapsed = 0;
        exp_led = '0; exp_busy = 1'b0; exp_err = 1'b0; exp_ack_vld = 1'b0; exp_ack_dat = 8'h00;
    endtask

    function automatic logic [LW-1:0] shown();
        if (m_mode == 1) return m_phase ? m_mask : '0;
        if (m_mode == 2) return m_chase;
        return m_mask;
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] d);
        logic       wr;
        logic [7:0] op;
        wr = 1'b0;
        op = d;
        exp_led = shown();
        exp_err = 1'b0;
        if (m_wait) begin
            if (v) begin
                if (m_opc == 8'h90) m_mask = d[LW-1:0];
                else                m_rate = int'(d);
                op = m_opc; wr = 1'b1; m_wait = 1'b0;
            end else begin
                m_wait_cnt++;
                if (m_wait_cnt == ATO) begin m_wait = 1'b0; exp_err = 1'b1; end
            end
        end else if (v) begin
            if (d >= 8'h80 && d <= 8'h85)      begin m_mask = presets[int'(d) - 128]; wr = 1'b1; end
            else if (d >= 8'hA0 && d <= 8'hA2) begin m_mode = int'(d) - 160; wr = 1'b1; end
            else if (d == 8'h90 || d == 8'hB0) begin m_wait = 1'b1; m_opc = d; m_wait_cnt = 0; end
            else exp_err = 1'b1;
        end
        m_elapsed++;
        if (wr) begin
            m_elapsed = 0; m_phase = 1'b1; m_chase = m_mask;
        end else if (m_elapsed % ((m_rate + 1) * TD) == 0) begin
            m_phase = ~m_phase;
            m_chase = {m_chase[LW-2:0], m_chase[LW-1]};
        end
        exp_busy    = m_wait;
        exp_ack_vld = wr;
        exp_ack_dat = wr ? op : 8'h00;
    endtask

    task automatic check_outputs(input string ctx);
        chk({ctx, ".led"}, 32'(led_out), 32'(exp_led));
        chk({ctx, ".busy"}, 32'(busy), 32'(exp_busy));
        chk({ctx, ".err"}, 32'(cmd_err), 32'(exp_err));
`ifdef LED_CMD_CTRL_ACK_EN
        chk({ctx, ".ack_vld"}, 32'(ack_valid), 32'(exp_ack_vld));
        if (exp_ack_vld) chk({ctx, ".ack_dat"}, 32'(ack_data), 32'(exp_ack_dat));
`endif
    endtask

    task automatic step(input logic v, input logic [7:0] d, input string ctx);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        rx_valid = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic idle(input int n, input string ctx);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, ctx);
    endtask

    task automatic do_reset(input string ctx);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs({ctx, ".async"});
        repeat (2) @(posedge clk);
        #1;
        check_outputs({ctx, ".held"});
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        logic [7:0] b;
        model_reset();
        #2;
        check_outputs("por");
        @(posedge clk); #1;
        do_reset("rst0");

        step(1'b1, 8'h83, "p83");
        chk("p83.noerr", 32'(cmd_err), 32'd0);
        step(1'b0, 8'h00, "p83.lat");
        chk("p83.led", 32'(led_out), 32'b0100);

        step(1'b1, 8'h90, "setm.op");
        chk("setm.busy", 32'(busy), 32'd1);
        idle(3, "setm.gap");
        step(1'b1, 8'h0A, "setm.arg");
        step(1'b0, 8'h00, "setm.lat");
        chk("setm.led", 32'(led_out), 32'b1010);

        step(1'b1, 8'h90, "to.op");
        idle(ATO + 2, "to.wait");
        chk("to.mask_kept", 32'(led_out), 32'b1010);

        step(1'b1, 8'h86, "bad86");
        chk("bad86.err", 32'(cmd_err), 32'd1);
        step(1'b1, 8'h41, "bad41");
        chk("bad41.err", 32'(cmd_err), 32'd1);

        step(1'b1, 8'hB0, "blink.op");
        step(1'b1, 8'h01, "blink.arg");
        step(1'b1, 8'h85, "blink.p85");
        step(1'b1, 8'hA1, "blink.mode");
        step(1'b0, 8'h00, "blink.first");
        chk("blink.start", 32'(led_out), 32'b1111);
        idle(8, "blink.run");
        chk("blink.off", 32'(led_out), 32'b0000);
        idle(30, "blink.run2");

        step(1'b1, 8'h81, "chase.p81");
        step(1'b1, 8'hA2, "chase.mode");
        idle(20, "chase.run");
        step(1'b1, 8'h84, "chase.p84");
        step(1'b0, 8'h00, "chase.restart");
        chk("chase.restart_led", 32'(led_out), 32'b1000);
        idle(20, "chase.run2");

        step(1'b1, 8'h90, "rstw.op");
        idle(2, "rstw.gap");
        do_reset("rstw");
        step(1'b1, 8'h0F, "rstw.byte");
        chk("rstw.discard", 32'(cmd_err), 32'd1);

        step(1'b1, 8'h85, "rstb.p85");
        step(1'b1, 8'hA1, "rstb.mode");
        idle(10, "rstb.run");
        do_reset("rstb");

`ifdef LED_CMD_CTRL_ACK_EN
        step(1'b1, 8'h82, "ack.p82");
        chk("ack.vld", 32'(ack_valid), 32'd1);
        chk("ack.dat", 32'(ack_data), 32'h82);
`endif

        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) begin
                step(1'b0, 8'h00, "rnd.idle");
            end else if (r == 50 && $urandom_range(0, 3) == 0) begin
                idle(ATO + 3, "rnd.long");
            end else if (r == 51 && $urandom_range(0, 9) == 0) begin
                do_reset("rnd.rst");
            end else begin
                if (m_wait) begin
                    b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                end else begin
                    case ($urandom_range(0, 5))
                        0, 1:    b = 8'h80 + 8'($urandom_range(0, 5));
                        2:       b = 8'hA0 + 8'($urandom_range(0, 2));
                        3:       b = 8'h90;
                        4:       b = 8'hB0;
                        default: b = 8'($urandom);
                    endcase
                end
                step(1'b1, b, "rnd.byte");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
